// File: rtl/mod_counter_arbiter.sv
// mod_counter_arbiter: round-robin sharing of one mod-N up-counter among
// four requesters. The owner counts 0..its latched limit, gets a one-cycle
// done pulse, and the counter is released after a one-cycle gap.
module mod_counter_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4   // must stay 4: pointer and owner are 2 bits wide
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   limit,
    input  logic                    hold,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        count,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       ptr_q;    // highest-priority requester for next arbitration
    logic [1:0]       own_q;    // index of the current owner
    logic [WIDTH-1:0] lim_q;    // terminal count captured at grant
    logic [1:0]       sel;
    logic             found;

    // Pick the first requester with req set, scanning upward from ptr_q.
    always_comb begin
        logic [1:0] cand;
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Grant/run/done sequencing and the shared counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            gnt   <= '0;
            count <= '0;
            done  <= '0;
            busy  <= 1'b0;
            ptr_q <= '0;
            own_q <= '0;
            lim_q <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt        <= '0;
                        gnt[sel]   <= 1'b1;
                        own_q      <= sel;
                        lim_q      <= limit[sel*WIDTH +: WIDTH];
                        count      <= '0;
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!req[own_q]) begin
                        // Owner withdrew: release without a done pulse.
                        gnt   <= '0;
                        count <= '0;
                        busy  <= 1'b0;
                        ptr_q <= own_q + 2'd1;
                        state <= S_IDLE;
                    end else if (hold) begin
                        // Paused: keep everything as is.
                    end else if (count == lim_q) begin
                        gnt         <= '0;
                        count       <= '0;
                        busy        <= 1'b0;
                        done[own_q] <= 1'b1;
                        ptr_q       <= own_q + 2'd1;
                        state       <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE: begin
                    // done clears via the default above; gap cycle before re-arbitration.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_counter_arbiter.sv
// Bench for mod_counter_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_mod_counter_arbiter;

    localparam int WIDTH = 3;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] limit = '0;
    logic                  hold = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the counter, how far it has counted,
    // and whether the one-cycle completion gap is in progress.
    int       m_owner = -1;
    int       m_cnt = 0;
    int       m_lim = 0;
    int       m_ptr = 0;
    bit       m_gap = 1'b0;
    logic [3:0] m_done = '0;

    mod_counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .limit(limit), .hold(hold),
        .gnt(gnt), .count(count), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int lim_of(int i);
        return int'((limit >> (i * WIDTH)) & ((1 << WIDTH) - 1));
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        m_done = '0;
        if (!rst) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0; m_gap = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (m_owner < 0 && req[i]) begin
                    m_owner = i; m_lim = lim_of(i); m_cnt = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_cnt = 0;
        end else if (hold) begin
            // frozen
        end else if (m_cnt == m_lim) begin
            m_done[m_owner] = 1'b1;
            m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_cnt = 0; m_gap = 1'b1;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: update model at the edge, then compare all outputs shortly after.
    task automatic step();
        int eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner < 0) ? 0 : (1 << m_owner);
        chk("gnt",   int'(gnt),   eg);
        chk("count", int'(count), m_cnt);
        chk("done",  int'(done),  int'(m_done));
        chk("busy",  int'(busy),  (m_owner >= 0) ? 1 : 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run until the model shows the given owner at the given count; bounded.
    task automatic wait_cnt(input int owner, input int target, input int budget);
        int n;
        n = 0;
        while (!(m_owner == owner && m_cnt == target) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (!(m_owner == owner && m_cnt == target)) begin
            miscompares++;
            $display("FAIL wait_cnt owner=%0d target=%0d not reached in %0d cycles", owner, target, budget);
        end
    endtask

    initial begin
        #1;
        // Reset held for two edges, then released.
        rst = 1'b0; steps(2);
        rst = 1'b1; steps(1);

        // Reset in the middle of a run: no done, all outputs cleared.
        req = 4'b0001; limit = 12'o0007;
        wait_cnt(0, 3, 10);
        rst = 1'b0; steps(1);
        rst = 1'b1; req = 4'b0000; steps(2);

        // Single requester, full mod-8 count.
        req = 4'b0001; limit = 12'o0007;
        wait_cnt(0, 7, 12);
        req = 4'b0000; steps(1);   // req sampled low at terminal edge -> abort path
        req = 4'b0001; steps(1);
        wait_cnt(0, 7, 12);
        steps(1);                  // terminal edge with req high -> done
        req = 4'b0000; steps(3);

        // Round-robin, limits 2,0,1,3 for requesters 0..3.
        limit = {3'd3, 3'd1, 3'd0, 3'd2};
        req = 4'b1111; steps(30);
        req = 4'b0000; steps(3);

        // Hold on requester 2 at count 2 for four cycles.
        limit = {3'd0, 3'd5, 3'd0, 3'd0};
        req = 4'b0100;
        wait_cnt(2, 2, 10);
        hold = 1'b1; steps(4);
        hold = 1'b0; steps(6);
        req = 4'b0000; steps(2);

        // Abort by requester 1 at count 3, then 0 and 3 pending.
        limit = {3'd2, 3'd0, 3'd6, 3'd0};
        req = 4'b0010;
        wait_cnt(1, 3, 10);
        req = 4'b0000; steps(1);
        req = 4'b1001; steps(2);
        vectors++;
        if (m_owner != 3) begin
            miscompares++;
            $display("FAIL abort_next_owner model owner=%0d expected=3", m_owner);
        end
        steps(4);
        req = 4'b0000; steps(6);

        // Limit latched at grant: changing it mid-run has no effect.
        limit = 12'o0004; req = 4'b0001;
        wait_cnt(0, 1, 10);
        limit = 12'o0001;
        steps(6);
        req = 4'b0000; steps(3);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            if ($urandom_range(5) == 0) limit = 12'($urandom);
            hold = ($urandom_range(7) == 0);
            rst  = ($urandom_range(60) != 0);
            step();
        end
        rst = 1'b1; hold = 1'b0; req = '0; steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
